// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter that shares one UART transmitter between the CPU and debug byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a grant whose owner stalls mid-packet for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       cpu_clk,
  input  logic       cpu_rst_n,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_data,
  input  logic       cpu_last,
  output logic       cpu_ready,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  input  logic       dbg_last,
  output logic       dbg_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_CPU = 2'd1,
    LOCK_DBG = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       rr_reg, rr_next;
  logic       tx_valid_reg, tx_valid_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [1:0] grant_reg, grant_next;
  logic       out_free, cpu_hs, dbg_hs, expire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || CNT_W < 1) begin : g_param_check
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  // The output register can take a new byte when empty or draining this cycle.
  assign out_free  = !tx_valid_reg || tx_ready;
  assign cpu_ready = (state_reg == LOCK_CPU) && out_free;
  assign dbg_ready = (state_reg == LOCK_DBG) && out_free;
  assign cpu_hs    = cpu_valid && cpu_ready;
  assign dbg_hs    = dbg_valid && dbg_ready;

`ifdef UART_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stall, pulse_reg;

  // Only owner idleness counts; transmitter backpressure drops ready and freezes the count.
  assign stall  = (cpu_ready && !cpu_valid) || (dbg_ready && !dbg_valid);
  assign expire = stall && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE || cpu_hs || dbg_hs || expire) begin
      cnt_next = '0;
    end else if (stall) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      pulse_reg <= expire;
    end
  end

  assign timeout_pulse = pulse_reg;
`else
  assign expire        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    rr_next       = rr_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_valid && dbg_valid) begin
          state_next = rr_reg ? LOCK_DBG : LOCK_CPU;
        end else if (cpu_valid) begin
          state_next = LOCK_CPU;
        end else if (dbg_valid) begin
          state_next = LOCK_DBG;
        end
      end
      LOCK_CPU: begin
        if ((cpu_hs && cpu_last) || expire) begin
          state_next = IDLE;
          rr_next    = 1'b1;
        end
      end
      LOCK_DBG: begin
        if ((dbg_hs && dbg_last) || expire) begin
          state_next = IDLE;
          rr_next    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (cpu_hs) begin
      tx_valid_next = 1'b1;
      tx_data_next  = cpu_data;
    end else if (dbg_hs) begin
      tx_valid_next = 1'b1;
      tx_data_next  = dbg_data;
    end else if (tx_ready) begin
      tx_valid_next = 1'b0;
    end

    grant_next = {state_next == LOCK_DBG, state_next == LOCK_CPU};
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_reg    <= IDLE;
      rr_reg       <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      grant_reg    <= 2'b00;
    end else begin
      state_reg    <= state_next;
      rr_reg       <= rr_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      grant_reg    <= grant_next;
    end
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign grant    = grant_reg;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-atomic arbiter sharing the single UART transmitter behind `txd` between two byte-stream requesters: the CPU's MMIO UART path and the debug trace streamer that serializes write-back records. Each requester sends packets as valid/ready byte streams with an end-of-packet flag. The grant holds for a whole packet, and ownership alternates round-robin at packet boundaries. The block sits between the requesters and the UART transmitter, in the `cpu_clk` domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: idle cycles a granted requester may stall mid-packet before the grant is revoked. Range 2..65535.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES+1)`: timeout counter width (derived; do not override).

Ports:
- `cpu_clk` in 1: the only clock.
- `cpu_rst_n` in 1: reset, asynchronous, active-low.
- `cpu_valid` in 1: CPU byte valid.
- `cpu_data` in 8: CPU byte.
- `cpu_last` in 1: CPU byte ends its packet.
- `cpu_ready` out 1: CPU byte accepted this cycle when `cpu_valid` is also high.
- `dbg_valid` in 1: debug byte valid.
- `dbg_data` in 8: debug byte.
- `dbg_last` in 1: debug byte ends its packet.
- `dbg_ready` out 1: debug byte accepted this cycle when `dbg_valid` is also high.
- `tx_valid` out 1: registered byte presented to the UART transmitter.
- `tx_data` out 8: registered byte to the transmitter.
- `tx_ready` in 1: transmitter accepts `tx_data`.
- `grant` out 2: one-hot owner; bit0 = CPU, bit1 = debug, 00 = none.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE, LOCK_CPU, LOCK_DBG. Round-robin pointer `rr`, 1 bit, 0 = CPU has priority next.
- **IDLE:**
  - Both `*_valid` high: go to LOCK of the requester `rr` favours.
  - Only one valid: go to that requester's LOCK.
  - No valid: stay in IDLE.
  - No `*_ready` is asserted in IDLE.
- **LOCK_x:**
  - `x_ready = !tx_valid | tx_ready`. The other requester's ready is 0.
  - On an x handshake: `tx_data <= x_data`, `tx_valid <= 1`.
  - On an x handshake with `x_last = 1`: go to IDLE and set `rr` to favour the other requester.
- **Output register:** `tx_valid` clears on a `tx_ready` handshake unless it is reloaded in the same cycle. `tx_data` holds its value while `tx_valid && !tx_ready`.
- Bytes are passed through unmodified, in order. Packets are never interleaved on `tx_data`.
- `grant` is decoded from the state, registered with it.
- **Reset:** state IDLE, `rr` = 0, `tx_valid` = 0, `tx_data` = 0, `grant` = 00, `timeout_pulse` = 0, both readys 0, timeout counter 0.
  - Reset mid-packet drops the byte in the output register.
  - Requesters must restart the packet after reset.

## Timing
- Request to grant: `x_valid` high in IDLE at cycle N gives `grant`/LOCK at N+1, and `x_ready` can first be high at N+1.
- Data latency: a handshake at cycle M gives `tx_valid`/`tx_data` at M+1.
- Throughput: 1 byte/cycle while `tx_ready` stays high.
- Packet turnaround: a `last` handshake at M gives IDLE at M+1 and the next grant at M+2.
- Simultaneous requests in IDLE: `rr` decides. `rr` is updated only at packet end or on timeout.
- A `last` handshake and a timeout expiry in the same cycle: the `last` handshake wins; no pulse is raised.
- `tx_ready` backpressure while locked freezes both the data path and the timeout counter (a stall is not the requester's fault).

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - In LOCK_x, the counter increments each cycle in which `x_ready` is high but `x_valid` is low. It clears on every x handshake and on entering LOCK.
  - When the counter reaches `TIMEOUT_CYCLES`: go to IDLE, flip `rr` to the other requester, and pulse `timeout_pulse` for 1 cycle.
  - The partial packet already sent is not recalled.
- **Undefined:**
  - Counter logic is absent and `timeout_pulse` is tied to 0.
  - The grant persists until `last`, however long that takes.

## Test plan
- CPU only: send bytes 0x41, 0x42, 0x43 with `last` on 0x43 and `tx_ready` = 1. Required: `grant` = 01 one cycle after `cpu_valid`; `tx_data` shows 0x41/0x42/0x43 on consecutive cycles; IDLE one cycle after 0x43 is accepted.
- Contention after reset, both valid in the same cycle. CPU packet is 0x10, 0x11(last); debug packet is 0xA0, 0xA1(last). Required: CPU wins (`rr` = 0); output sequence is 0x10, 0x11, 0xA0, 0xA1; `dbg_ready` stays 0 during the CPU packet.
- Fairness: both requesters hold `valid` high continuously with 1-byte packets (`last` = 1). Required: `grant` alternates 01, 10, 01, 10.
- Backpressure: hold `tx_ready` = 0 for 5 cycles mid-packet. Required: `tx_data` is stable, `cpu_ready` = 0, no byte is lost or duplicated, and no `timeout_pulse` occurs.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 8): debug sends 0xA0 without `last`, then drops `dbg_valid`. Required: after 8 stalled cycles `timeout_pulse` = 1 for exactly 1 cycle, `grant` = 00, and a pending CPU request is granted next. With the macro undefined, the grant stays 10 indefinitely.
- Async reset: assert `cpu_rst_n` = 0 mid-packet with `tx_valid` = 1. Required: `tx_valid`, `grant`, and both readys are 0 immediately, independent of `cpu_clk`.
